// File: rtl/gbe_cpu_rx_buffer_pkg.sv
// Shared definitions for the CPU receive buffer: default sizes, write FSM
// state encoding and the byte-lane placement helper.
package gbe_cpu_rx_buffer_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_SIZE_WIDTH = 8;
    localparam int DEF_MAX_BYTES  = (2**DEF_SIZE_WIDTH - 1) * 8;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_FILL    = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_t;

    // Big-endian packing: lane 0 is the first byte on the wire -> [31:24].
    function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] lane);
        case (lane)
            2'd0:    return {b, 24'h0};
            2'd1:    return {8'h0, b, 16'h0};
            2'd2:    return {16'h0, b, 8'h0};
            default: return {24'h0, b};
        endcase
    endfunction

endpackage

// File: rtl/gbe_rx_bank_ram.sv
// Simple dual-port RAM holding both banks; the bank select is the address MSB.
// One write port, one registered read port.
module gbe_rx_bank_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**AW)-1];

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; output register clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/gbe_cpu_rx_buffer.sv
// Double-buffered CPU receive store: packs the incoming byte stream into one
// of two banks and presents the oldest complete frame to the CPU.
module gbe_cpu_rx_buffer
    import gbe_cpu_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
    parameter int MAX_BYTES  = DEF_MAX_BYTES
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [7:0]            rx_data,
    input  logic                  rx_dvld,
    input  logic                  rx_eof,
    input  logic                  rx_bad,
    input  logic [ADDR_WIDTH-1:0] cpu_rx_buffer_addr,
    output logic [31:0]           cpu_rx_buffer_rd_data,
    output logic [SIZE_WIDTH-1:0] cpu_rx_size,
    output logic                  cpu_rx_ready,
    input  logic                  cpu_rx_ack,
    output logic                  rx_overrun,
    output logic [15:0]           rx_drop_count
);

    // Byte counter spans one bank: word index in the upper bits, lane in [1:0].
    localparam int CW = ADDR_WIDTH + 2;

    wr_state_t                        state;
    logic [CW-1:0]                    byte_cnt;
    logic [31:0]                      wacc;
    logic [1:0]                       full, full_nxt;
    logic [1:0][SIZE_WIDTH-1:0]       size_q;
    logic                             fill_bank, cpu_bank;
    logic                             ack_q, ack_block;

    logic [31:0]           word_cur;
    logic                  accept, no_bank, too_big, good_eof;
    logic                  ram_we, drop_ev, overrun_ev, release_ev;
    logic [SIZE_WIDTH-1:0] new_size;

    // Decode the current byte against the write state and bank occupancy.
    always_comb begin
        word_cur   = wacc | place_byte(rx_data, byte_cnt[1:0]);
        no_bank    = (state == WR_IDLE) && full[fill_bank];
        accept     = rx_dvld && (((state == WR_IDLE) && !full[fill_bank]) || (state == WR_FILL));
        too_big    = (state == WR_FILL) && (byte_cnt == CW'(MAX_BYTES));
        good_eof   = accept && !too_big && rx_eof && !rx_bad;
        ram_we     = accept && !too_big && ((byte_cnt[1:0] == 2'd3) || rx_eof);
        overrun_ev = rx_dvld && no_bank;
        drop_ev    = overrun_ev || (accept && too_big) || (accept && !too_big && rx_eof && rx_bad);
        // byte_cnt is the index of the eof byte, so bytes = byte_cnt + 1.
        new_size   = SIZE_WIDTH'((byte_cnt + CW'(8)) >> 3);
        release_ev = cpu_rx_ack && !ack_q && cpu_rx_ready;
        full_nxt   = full;
        if (good_eof)   full_nxt[fill_bank] = 1'b1;
        if (release_ev) full_nxt[cpu_bank]  = 1'b0;
    end

    // Write FSM: frame assembly, discard handling, overrun pulse, drop counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= WR_IDLE;
            byte_cnt      <= '0;
            wacc          <= '0;
            rx_overrun    <= 1'b0;
            rx_drop_count <= '0;
        end else begin
            rx_overrun <= overrun_ev;
            if (drop_ev && (rx_drop_count != 16'hFFFF))
                rx_drop_count <= rx_drop_count + 16'd1;
            case (state)
                WR_IDLE, WR_FILL: begin
                    if (rx_dvld) begin
                        if (!accept) begin
                            state <= rx_eof ? WR_IDLE : WR_DISCARD;
                        end else if (too_big || rx_eof) begin
                            state    <= (too_big && !rx_eof) ? WR_DISCARD : WR_IDLE;
                            byte_cnt <= '0;
                            wacc     <= '0;
                        end else begin
                            state    <= WR_FILL;
                            byte_cnt <= byte_cnt + CW'(1);
                            wacc     <= (byte_cnt[1:0] == 2'd3) ? 32'h0 : word_cur;
                        end
                    end
                end
                WR_DISCARD: if (rx_dvld && rx_eof) state <= WR_IDLE;
                default:    state <= WR_IDLE;
            endcase
        end
    end

    // Bank bookkeeping: completion fills one bank while a CPU release frees the other.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            full      <= '0;
            size_q    <= '0;
            fill_bank <= 1'b0;
            cpu_bank  <= 1'b0;
            ack_q     <= 1'b0;
            ack_block <= 1'b0;
        end else begin
            full  <= full_nxt;
            ack_q <= cpu_rx_ack;
            if (good_eof) begin
                size_q[fill_bank] <= new_size;
                fill_bank         <= ~fill_bank;
            end
            if (release_ev) cpu_bank <= ~cpu_bank;
            // Hide the next frame until the CPU drops its acknowledge.
            ack_block <= cpu_rx_ack && (ack_block || release_ev);
        end
    end

    assign cpu_rx_ready = full[cpu_bank] && !ack_block;
    assign cpu_rx_size  = cpu_rx_ready ? size_q[cpu_bank] : '0;

    gbe_rx_bank_ram #(.AW(ADDR_WIDTH + 1)) u_ram (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .we    (ram_we),
        .waddr ({fill_bank, byte_cnt[CW-1:2]}),
        .wdata (word_cur),
        .raddr ({cpu_bank, cpu_rx_buffer_addr}),
        .rdata (cpu_rx_buffer_rd_data)
    );

endmodule

// File: tb/tb_gbe_cpu_rx_buffer.sv
// Scoreboard bench for the CPU receive buffer: expected frames are queued as
// they are sent and compared word by word when the CPU side presents them.
module tb_gbe_cpu_rx_buffer;

    localparam int MAXB = 2040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_dvld = 1'b0, rx_eof = 1'b0, rx_bad = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [7:0]  rx_size;
    logic        rx_ready, rx_ack = 1'b0, rx_ov;
    logic [15:0] drop_cnt;

    int n_tests = 0, n_fail = 0;
    int mdl_cnt = 0, exp_drop = 0, exp_ov = 0, ov_cnt = 0;
    logic [31:0] exp_w[$];
    int          exp_n[$];
    int          exp_s[$];
    logic [7:0]  fbuf [0:2047];

    always #5 clk = ~clk;

    gbe_cpu_rx_buffer dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data(rx_data), .rx_dvld(rx_dvld), .rx_eof(rx_eof), .rx_bad(rx_bad),
        .cpu_rx_buffer_addr(rd_addr), .cpu_rx_buffer_rd_data(rd_data),
        .cpu_rx_size(rx_size), .cpu_rx_ready(rx_ready), .cpu_rx_ack(rx_ack),
        .rx_overrun(rx_ov), .rx_drop_count(drop_cnt)
    );

    always @(negedge clk) if (!rst && rx_ov) ov_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fword(input int i, input int len);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++)
            if (4*i + j < len) w[31-8*j -: 8] = fbuf[4*i + j];
        return w;
    endfunction

    task automatic fill_inc(input int len, input logic [7:0] start);
        for (int i = 0; i < len; i++) fbuf[i] = start + 8'(i);
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
    endtask

    // Drive one frame from fbuf; the bench model decides its fate up front.
    task automatic send_frame(input int len, input bit bad, input bit lat);
        if (mdl_cnt == 2) begin
            exp_ov++; exp_drop++;
        end else if (bad || len > MAXB) begin
            exp_drop++;
        end else begin
            mdl_cnt++;
            exp_s.push_back((len + 7) / 8);
            exp_n.push_back((len + 3) / 4);
            for (int i = 0; i < (len + 3) / 4; i++) exp_w.push_back(fword(i, len));
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_dvld = 1'b1; rx_data = fbuf[i];
            rx_eof  = (i == len - 1);
            rx_bad  = (i == len - 1) && bad;
        end
        if (lat) chk("lat_before_eof", rx_ready, 0);
        @(negedge clk);
        rx_dvld = 1'b0; rx_eof = 1'b0; rx_bad = 1'b0;
        if (lat) chk("lat_after_eof", rx_ready, 1);
    endtask

    task automatic read_words(input string tag);
        int n = 0, nw;
        while (!rx_ready && n < 64) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, rx_ready, 1);
        if (exp_s.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_sb: frame presented, none expected", tag);
            return;
        end
        chk({tag, "_size"}, rx_size, exp_s.pop_front());
        nw = exp_n.pop_front();
        for (int i = 0; i < nw; i++) begin
            rd_addr = 9'(i);
            @(negedge clk);
            chk($sformatf("%s_w%0d", tag, i), rd_data, exp_w.pop_front());
        end
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk); rx_ack = 1'b1;
        @(negedge clk);
        chk({tag, "_ack_hi_ready"}, rx_ready, 0);
        chk({tag, "_ack_hi_size"}, rx_size, 0);
        rx_ack = 1'b0; mdl_cnt--;
        @(negedge clk);
        chk({tag, "_ack_lo_ready"}, rx_ready, (mdl_cnt > 0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_size", rx_size, 0);
        chk("rst_ready", rx_ready, 0);
        chk("rst_overrun", rx_ov, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // 64-byte incrementing frame with latency check
        fill_inc(64, 8'h00);
        send_frame(64, 0, 1);
        read_words("f64"); do_ack("f64");

        // 5-byte and 1-byte frames
        fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC; fbuf[3] = 8'hDD; fbuf[4] = 8'hEE;
        send_frame(5, 0, 0);
        read_words("f5"); do_ack("f5");
        fbuf[0] = 8'h5A;
        send_frame(1, 0, 0);
        read_words("f1"); do_ack("f1");

        // Three frames without ack: third overruns
        fill_rand(10); send_frame(10, 0, 0);
        fill_rand(20); send_frame(20, 0, 0);
        fill_rand(30); send_frame(30, 0, 0);
        @(negedge clk);
        chk("ovr_pulses", ov_cnt, exp_ov);
        chk("ovr_drop", drop_cnt, exp_drop);
        read_words("ovr_a"); do_ack("ovr_a");
        read_words("ovr_b"); do_ack("ovr_b");

        // Oversize frame then a normal 60-byte frame
        fill_rand(MAXB + 1); send_frame(MAXB + 1, 0, 0);
        @(negedge clk);
        chk("big_ready", rx_ready, 0);
        chk("big_drop", drop_cnt, exp_drop);
        fill_inc(60, 8'h40); send_frame(60, 0, 0);
        read_words("f60"); do_ack("f60");

        // Bad frame
        fill_rand(12); send_frame(12, 1, 0);
        @(negedge clk);
        chk("bad_ready", rx_ready, 0);
        chk("bad_drop", drop_cnt, exp_drop);

        // Eof of frame B lands on the same edge as the ack of frame A
        fill_rand(16); send_frame(16, 0, 0);
        read_words("coA");
        fill_rand(8);
        fork
            send_frame(8, 0, 0);
            begin
                repeat (8) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                chk("co_ack_hi_ready", rx_ready, 0);
                rx_ack = 1'b0; mdl_cnt--;
                @(negedge clk);
                chk("co_ack_lo_ready", rx_ready, 1);
            end
        join
        read_words("coB"); do_ack("coB");
        chk("co_drop", drop_cnt, exp_drop);

        // Reset while one frame is presented and another is being filled
        fill_rand(24); send_frame(24, 0, 0);
        chk("pre_rst_ready", rx_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); rx_dvld = 1'b1; rx_data = 8'(i + 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", rx_ready, 0);
        chk("mid_rst_size", rx_size, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_overrun", rx_ov, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        @(negedge clk);
        rx_dvld = 1'b0;
        exp_w.delete(); exp_n.delete(); exp_s.delete();
        mdl_cnt = 0; exp_drop = 0; exp_ov = 0; ov_cnt = 0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        fill_rand(13); send_frame(13, 0, 0);
        read_words("post_rst"); do_ack("post_rst");
        chk("post_rst_drop", drop_cnt, exp_drop);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
